// File: rtl/ibex_lsu_split.sv
// Load/store unit sitting behind the EX stage. Misaligned word and halfword
// accesses go out as two aligned bus transactions, and the two read words
// are stitched back together before extension. Only one bus transaction is
// in flight at any time.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no access in progress; a request is accepted here
// WAIT_GNT1 | first bus request raised, waiting for grant
// WAIT_RV1  | first request granted, waiting for its response
// WAIT_GNT2 | second (upper word) request raised, waiting for grant
// WAIT_RV2  | second request granted, waiting for its response
module ibex_lsu_split #(
  parameter int unsigned DataBusW = 32,
  parameter bit          SplitEn  = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [1:0]          lsu_type_i,
  input  logic                lsu_sign_ext_i,
  input  logic [DataBusW-1:0] lsu_wdata_i,
  input  logic [31:0]         adder_result_ex_i,
  output logic                data_req_o,
  input  logic                data_gnt_i,
  input  logic                data_rvalid_i,
  input  logic                data_err_i,
  output logic [31:0]         data_addr_o,
  output logic                data_we_o,
  output logic [3:0]          data_be_o,
  output logic [DataBusW-1:0] data_wdata_o,
  input  logic [DataBusW-1:0] data_rdata_i,
  output logic [DataBusW-1:0] lsu_rdata_o,
  output logic                lsu_resp_valid_o,
  output logic                lsu_err_o,
  output logic                busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT1,
    WAIT_RV1,
    WAIT_GNT2,
    WAIT_RV2
  } state_e;

  // Access size as held internally; the reserved type code folds into word.
  localparam logic [1:0] SzWord = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzByte = 2'b10;

  state_e              state_q;
  logic [29:0]         addr_q;
  logic [1:0]          off_q;
  logic [1:0]          sz_q;
  logic                we_q;
  logic                sext_q;
  logic                split_q;
  logic                misal_q;
  logic                err_q;
  logic [DataBusW-1:0] wdata_q;
  logic [DataBusW-1:0] rdata_q;
  logic [DataBusW-1:0] rdata_hold_q;
  logic                err_hold_q;

  logic [1:0]          req_sz;
  logic [1:0]          req_off;
  logic                req_mis;
  logic                req_split;
  logic                req_mis_err;

  logic [2*DataBusW-1:0] rd_comb;
  logic [DataBusW-1:0]   rd_low;
  logic [DataBusW-1:0]   rd_ext;
  logic                  resp_fire;
  logic                  resp_err;
  logic [DataBusW-1:0]   resp_rdata;

  // Byte enables of the first (lower) word of an access.
  function automatic logic [3:0] be_part1(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    unique case (sz)
      SzHalf: begin
        unique case (off)
          2'd0:    be = 4'b0011;
          2'd1:    be = 4'b0110;
          2'd2:    be = 4'b1100;
          default: be = 4'b1000;
        endcase
      end
      SzByte:  be = 4'b0001 << off;
      default: be = 4'b1111 << off;
    endcase
    return be;
  endfunction

  // Byte enables of the upper word; only meaningful when the access splits.
  function automatic logic [3:0] be_part2(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    unique case (sz)
      SzHalf:  be = 4'b0001;
      SzByte:  be = 4'b0000;
      default: be = 4'b1111 >> (3'd4 - {1'b0, off});
    endcase
    return be;
  endfunction

  // Store data moved onto the byte lanes selected by the address offset.
  function automatic logic [31:0] rotl_lanes(input logic [31:0] d, input logic [1:0] off);
    logic [31:0] r;
    unique case (off)
      2'd0:    r = d;
      2'd1:    r = {d[23:0], d[31:24]};
      2'd2:    r = {d[15:0], d[31:16]};
      default: r = {d[7:0], d[31:8]};
    endcase
    return r;
  endfunction

  // Decode the live request: size, offset and whether it crosses a word.
  always_comb begin
    req_sz      = (lsu_type_i == 2'b11) ? SzWord : lsu_type_i;
    req_mis     = ((req_sz == SzWord) && (adder_result_ex_i[1:0] != 2'd0)) ||
                  ((req_sz == SzHalf) && (adder_result_ex_i[1:0] == 2'd3));
    req_split   = SplitEn && req_mis;
    // Without splitting, a misaligned access is issued as if aligned and
    // reported as an error when it completes.
    req_mis_err = !SplitEn && req_mis;
    req_off     = req_mis_err ? 2'd0 : adder_result_ex_i[1:0];
  end

  // Bus request side: live inputs in IDLE, captured values while waiting.
  always_comb begin
    data_req_o   = 1'b0;
    data_addr_o  = 32'h0;
    data_we_o    = 1'b0;
    data_be_o    = 4'b0000;
    data_wdata_o = '0;
    unique case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          data_req_o   = 1'b1;
          data_addr_o  = {adder_result_ex_i[31:2], 2'b00};
          data_we_o    = lsu_we_i;
          data_be_o    = be_part1(req_sz, req_off);
          data_wdata_o = rotl_lanes(lsu_wdata_i, req_off);
        end
      end
      WAIT_GNT1: begin
        data_req_o   = 1'b1;
        data_addr_o  = {addr_q, 2'b00};
        data_we_o    = we_q;
        data_be_o    = be_part1(sz_q, off_q);
        data_wdata_o = wdata_q;
      end
      WAIT_GNT2: begin
        data_req_o   = 1'b1;
        data_addr_o  = {addr_q + 30'd1, 2'b00};
        data_we_o    = we_q;
        data_be_o    = be_part2(sz_q, off_q);
        data_wdata_o = wdata_q;
      end
      default: begin
        data_req_o = 1'b0;
      end
    endcase
  end

  // Reassemble the (possibly two-word) load data and extend it.
  always_comb begin
    rd_comb = split_q ? {data_rdata_i, rdata_q} : {{DataBusW{1'b0}}, data_rdata_i};
    rd_low  = DataBusW'(rd_comb >> {off_q, 3'b000});
    unique case (sz_q)
      SzByte:  rd_ext = {{24{sext_q & rd_low[7]}}, rd_low[7:0]};
      SzHalf:  rd_ext = {{16{sext_q & rd_low[15]}}, rd_low[15:0]};
      default: rd_ext = rd_low;
    endcase
  end

  assign resp_fire  = data_rvalid_i &&
                      (((state_q == WAIT_RV1) && !split_q) || (state_q == WAIT_RV2));
  assign resp_err   = err_q | data_err_i | misal_q;
  assign resp_rdata = (we_q || resp_err) ? '0 : rd_ext;

  assign lsu_resp_valid_o = resp_fire;
  assign lsu_rdata_o      = resp_fire ? resp_rdata : rdata_hold_q;
  assign lsu_err_o        = resp_fire ? resp_err : err_hold_q;
  assign busy_o           = (state_q != IDLE);

  // Access sequencing and capture of the accepted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      sz_q    <= '0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      split_q <= 1'b0;
      misal_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (lsu_req_i) begin
            addr_q  <= adder_result_ex_i[31:2];
            off_q   <= req_off;
            sz_q    <= req_sz;
            we_q    <= lsu_we_i;
            sext_q  <= lsu_sign_ext_i;
            split_q <= req_split;
            misal_q <= req_mis_err;
            err_q   <= 1'b0;
            wdata_q <= rotl_lanes(lsu_wdata_i, req_off);
            state_q <= data_gnt_i ? WAIT_RV1 : WAIT_GNT1;
          end
        end
        WAIT_GNT1: begin
          if (data_gnt_i) state_q <= WAIT_RV1;
        end
        WAIT_RV1: begin
          if (data_rvalid_i) begin
            if (split_q) begin
              // A failed lower half still completes the upper half.
              rdata_q <= data_rdata_i;
              err_q   <= err_q | data_err_i;
              state_q <= WAIT_GNT2;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        WAIT_GNT2: begin
          if (data_gnt_i) state_q <= WAIT_RV2;
        end
        WAIT_RV2: begin
          if (data_rvalid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Keep the last response visible until the next one replaces it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_hold_q <= '0;
      err_hold_q   <= 1'b0;
    end else if (resp_fire) begin
      rdata_hold_q <= resp_rdata;
      err_hold_q   <= resp_err;
    end
  end

endmodule

// File: tb/tb_ibex_lsu_split.sv
// Bench for ibex_lsu_split: a bus responder driven from a directed/random
// schedule, with expectations computed byte-by-byte from the access address.
module tb_ibex_lsu_split;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [1:0]  lsu_type_i;
  logic        lsu_sign_ext_i;
  logic [31:0] lsu_wdata_i;
  logic [31:0] adder_result_ex_i;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_err_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_resp_valid_o;
  logic        lsu_err_o;
  logic        busy_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  ibex_lsu_split dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .lsu_req_i        (lsu_req_i),
    .lsu_we_i         (lsu_we_i),
    .lsu_type_i       (lsu_type_i),
    .lsu_sign_ext_i   (lsu_sign_ext_i),
    .lsu_wdata_i      (lsu_wdata_i),
    .adder_result_ex_i(adder_result_ex_i),
    .data_req_o       (data_req_o),
    .data_gnt_i       (data_gnt_i),
    .data_rvalid_i    (data_rvalid_i),
    .data_err_i       (data_err_i),
    .data_addr_o      (data_addr_o),
    .data_we_o        (data_we_o),
    .data_be_o        (data_be_o),
    .data_wdata_o     (data_wdata_o),
    .data_rdata_i     (data_rdata_i),
    .lsu_rdata_o      (lsu_rdata_o),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .lsu_err_o        (lsu_err_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access: drives the request, plays the bus side with the
  // given grant/response delays, and checks every cycle against the model.
  task automatic access(input logic we, input logic [1:0] typ, input logic sext,
                        input logic [31:0] wdata, input logic [31:0] addr,
                        input int gd1, input int rd1, input int gd2, input int rd2,
                        input logic [31:0] rw1, input logic [31:0] rw2,
                        input logic e1, input logic e2);
    int          nb;
    int          off;
    int          nparts;
    int          gd;
    int          rd;
    logic [3:0]  exp_be[2];
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    logic [31:0] res;
    logic [31:0] w;
    logic [31:0] base;
    logic        exp_err;

    nb        = (typ == 2'b01) ? 2 : (typ == 2'b10) ? 1 : 4;
    off       = int'(addr[1:0]);
    nparts    = (off + nb > 4) ? 2 : 1;
    base      = {addr[31:2], 2'b00};
    exp_be[0] = 4'b0000;
    exp_be[1] = 4'b0000;
    res       = 32'h0;
    for (int i = 0; i < nb; i++) begin
      int pos;
      pos = off + i;
      exp_be[pos / 4][pos % 4] = 1'b1;
      w = (pos < 4) ? rw1 : rw2;
      res[8*i +: 8] = w[8*(pos % 4) +: 8];
    end
    if (sext && res[8*nb-1]) begin
      for (int b = 8 * nb; b < 32; b++) res[b] = 1'b1;
    end
    for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wdata[8*((j - off + 4) % 4) +: 8];
    exp_err = e1 | ((nparts == 2) && e2);
    exp_rd  = (we || exp_err) ? 32'h0 : res;

    @(negedge clk_i);
    lsu_req_i         = 1'b1;
    lsu_we_i          = we;
    lsu_type_i        = typ;
    lsu_sign_ext_i    = sext;
    lsu_wdata_i       = wdata;
    adder_result_ex_i = addr;

    for (int p = 0; p < nparts; p++) begin
      gd = (p == 0) ? gd1 : gd2;
      rd = (p == 0) ? rd1 : rd2;
      for (int g = 0; g <= gd; g++) begin
        if (!(p == 0 && g == 0)) begin
          @(negedge clk_i);
          lsu_req_i         = 1'($urandom_range(0, 1));
          adder_result_ex_i = $urandom;
          lsu_wdata_i       = $urandom;
        end
        data_gnt_i    = (g == gd);
        data_rvalid_i = (g < gd) ? 1'($urandom_range(0, 1)) : 1'b0;
        data_err_i    = 1'($urandom_range(0, 1));
        data_rdata_i  = $urandom;
        #1;
        chk("req_phase_req", data_req_o, 1);
        chk("req_phase_addr", data_addr_o, base + 32'(4 * p));
        chk("req_phase_be", data_be_o, exp_be[p]);
        chk("req_phase_wdata", data_wdata_o, exp_wd);
        chk("req_phase_we", data_we_o, we);
        chk("req_phase_resp", lsu_resp_valid_o, 0);
        chk("req_phase_busy", busy_o, (p == 0 && g == 0) ? 1'b0 : 1'b1);
        @(posedge clk_i);
      end
      for (int r = 0; r <= rd; r++) begin
        @(negedge clk_i);
        lsu_req_i         = 1'($urandom_range(0, 1));
        adder_result_ex_i = $urandom;
        data_gnt_i        = (r < rd) ? 1'($urandom_range(0, 1)) : 1'b0;
        data_rvalid_i     = (r == rd);
        data_rdata_i      = (r == rd) ? ((p == 0) ? rw1 : rw2) : $urandom;
        data_err_i        = (r == rd) ? ((p == 0) ? e1 : e2) : 1'b0;
        #1;
        chk("rsp_phase_req", data_req_o, 0);
        chk("rsp_phase_busy", busy_o, 1);
        if (r == rd && p == nparts - 1) begin
          chk("resp_valid", lsu_resp_valid_o, 1);
          chk("resp_rdata", lsu_rdata_o, exp_rd);
          chk("resp_err", lsu_err_o, exp_err);
        end else begin
          chk("resp_early", lsu_resp_valid_o, 0);
        end
        @(posedge clk_i);
      end
    end

    last_rdata = exp_rd;
    last_err   = exp_err;
    @(negedge clk_i);
    lsu_req_i     = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    #1;
    chk("post_busy", busy_o, 0);
    chk("post_resp", lsu_resp_valid_o, 0);
    chk("post_req", data_req_o, 0);
    chk("hold_rdata", lsu_rdata_o, last_rdata);
    chk("hold_err", lsu_err_o, last_err);
  endtask

  initial begin
    logic [31:0] a;
    rst_ni            = 1'b0;
    lsu_req_i         = 1'b0;
    lsu_we_i          = 1'b0;
    lsu_type_i        = 2'b00;
    lsu_sign_ext_i    = 1'b0;
    lsu_wdata_i       = 32'h0;
    adder_result_ex_i = 32'h0;
    data_gnt_i        = 1'b0;
    data_rvalid_i     = 1'b0;
    data_err_i        = 1'b0;
    data_rdata_i      = 32'h0;

    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_req", data_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_resp", lsu_resp_valid_o, 0);
    chk("rst_rdata", lsu_rdata_o, 0);
    chk("rst_err", lsu_err_o, 0);
    chk("rst_addr", data_addr_o, 0);
    chk("rst_be", data_be_o, 0);
    chk("rst_wdata", data_wdata_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // aligned load word, response two cycles after the grant cycle
    access(1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_0100, 0, 1, 0, 0,
           32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    chk("t1_literal", lsu_rdata_o, 32'hDEAD_BEEF);
    // misaligned store word
    access(1'b1, 2'b00, 1'b0, 32'h1122_3344, 32'h0000_0102, 0, 0, 0, 0,
           32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0);
    chk("t2_literal_err", lsu_err_o, 0);
    // split signed halfword load
    access(1'b0, 2'b01, 1'b1, 32'h0, 32'h0000_0203, 0, 0, 0, 0,
           32'h80FF_FFFF, 32'hFFFF_FF12, 1'b0, 1'b0);
    chk("t3_literal", lsu_rdata_o, 32'h0000_1280);
    // signed byte with a slow grant
    access(1'b0, 2'b10, 1'b1, 32'h0, 32'h0000_0003, 3, 0, 0, 0,
           32'h8000_0000, 32'h0, 1'b0, 1'b0);
    chk("t4_literal", lsu_rdata_o, 32'hFFFF_FF80);
    // wrap across the top of the address space with a lower-half error
    access(1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFFE, 0, 0, 1, 0,
           32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    chk("t5_literal_err", lsu_err_o, 1);
    chk("t5_literal_rdata", lsu_rdata_o, 0);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a[31:2] = 30'h3FFF_FFFF;
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, a,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
             $urandom, $urandom,
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    // reset while the upper half of a split access is outstanding
    @(negedge clk_i);
    lsu_req_i         = 1'b1;
    lsu_we_i          = 1'b0;
    lsu_type_i        = 2'b00;
    lsu_sign_ext_i    = 1'b0;
    adder_result_ex_i = 32'h0000_0102;
    data_gnt_i        = 1'b1;
    data_rvalid_i     = 1'b0;
    #1;
    chk("t6_req1", data_req_o, 1);
    @(posedge clk_i);
    @(negedge clk_i);
    lsu_req_i     = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b1;
    data_err_i    = 1'b0;
    data_rdata_i  = 32'h0000_0055;
    #1;
    chk("t6_no_resp_part1", lsu_resp_valid_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    data_gnt_i    = 1'b1;
    #1;
    chk("t6_req2", data_req_o, 1);
    chk("t6_addr2", data_addr_o, 32'h0000_0104);
    @(posedge clk_i);
    @(negedge clk_i);
    data_gnt_i = 1'b0;
    #1;
    chk("t6_busy_before", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_req", data_req_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_resp", lsu_resp_valid_o, 0);
    chk("t6_rst_rdata", lsu_rdata_o, 0);
    chk("t6_rst_err", lsu_err_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    data_rvalid_i = 1'b1;
    data_rdata_i  = $urandom;
    #1;
    chk("t6_late_rv_resp", lsu_resp_valid_o, 0);
    chk("t6_late_rv_busy", busy_o, 0);
    chk("t6_late_rv_rdata", lsu_rdata_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    #1;
    chk("t6_after_resp", lsu_resp_valid_o, 0);
    chk("t6_after_busy", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
